// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the bridge FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

endpackage

// File: rtl/ahb_wstrb_decode.sv
// Maps core byte strobes to an AHB transfer shape; only naturally aligned
// byte, halfword and word accesses are legal.
module ahb_wstrb_decode
  import ahb_pkg::*;
(
  input  logic [3:0] wstrb,
  output logic       legal,
  output logic       hwrite,
  output logic [2:0] hsize,
  output logic [1:0] addr_lo
);

  always_comb begin
    legal   = 1'b1;
    hwrite  = 1'b1;
    hsize   = HSIZE_BYTE;
    addr_lo = 2'b00;
    case (wstrb)
      4'b0000: begin hwrite = 1'b0; hsize = HSIZE_WORD; end
      4'b0001: addr_lo = 2'b00;
      4'b0010: addr_lo = 2'b01;
      4'b0100: addr_lo = 2'b10;
      4'b1000: addr_lo = 2'b11;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
      4'b1111: hsize = HSIZE_WORD;
      default: begin legal = 1'b0; hwrite = 1'b0; end
    endcase
  end

endmodule

// File: rtl/ahb_master_bridge.sv
// Bridges the PRV32 valid/ready memory port onto AHB-Lite, one SINGLE
// NONSEQ transfer at a time, with every output driven from a register.
module ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter int   ADDR_WIDTH = 32,
  parameter logic HPROT_PRIV = 1'b1
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  mem_err,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic [1:0]            hresp
);

  state_t                  state, state_nxt;
  logic [1:0]              htrans_nxt;
  logic                    hwrite_nxt;
  logic [2:0]              hsize_nxt;
  logic [3:0]              hprot_nxt;
  logic [ADDR_WIDTH-1:0]   haddr_nxt;
  logic [31:0]             hwdata_nxt;
  logic                    ready_nxt;
  logic                    err_nxt;
  logic [31:0]             rdata_nxt;

  logic                    dec_legal;
  logic                    dec_hwrite;
  logic [2:0]              dec_hsize;
  logic [1:0]              dec_addr_lo;

  // hresp[1] and the core's byte offset carry no information here.
  logic                    unused_bits;
  assign unused_bits = ^{hresp[1], mem_addr[1:0]};

  assign hburst = HBURST_SINGLE;

  ahb_wstrb_decode u_wstrb_decode (
    .wstrb   (mem_wstrb),
    .legal   (dec_legal),
    .hwrite  (dec_hwrite),
    .hsize   (dec_hsize),
    .addr_lo (dec_addr_lo)
  );

  always_comb begin
    state_nxt  = state;
    htrans_nxt = htrans;
    hwrite_nxt = hwrite;
    hsize_nxt  = hsize;
    hprot_nxt  = hprot;
    haddr_nxt  = haddr;
    hwdata_nxt = hwdata;
    ready_nxt  = 1'b0;
    err_nxt    = 1'b0;
    rdata_nxt  = mem_rdata;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (dec_legal) begin
            state_nxt  = ST_ADDR;
            htrans_nxt = HTRANS_NONSEQ;
            hwrite_nxt = dec_hwrite;
            hsize_nxt  = dec_hsize;
            haddr_nxt  = {mem_addr[ADDR_WIDTH-1:2], dec_addr_lo};
            hwdata_nxt = mem_wdata;
            hprot_nxt  = {2'b00, HPROT_PRIV, ~mem_instr};
          end else begin
            // Illegal strobe: report the error without touching the bus.
            state_nxt = ST_RESP;
            ready_nxt = 1'b1;
            err_nxt   = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_nxt  = ST_DATA;
          htrans_nxt = HTRANS_IDLE;
        end
      end
      ST_DATA: begin
        if (hready) begin
          state_nxt = ST_RESP;
          ready_nxt = 1'b1;
          err_nxt   = (hresp[0] == HRESP_ERROR[0]);
          if (!hwrite) rdata_nxt = hrdata;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= ST_IDLE;
      htrans    <= HTRANS_IDLE;
      hwrite    <= 1'b0;
      hsize     <= HSIZE_WORD;
      hprot     <= 4'b0000;
      haddr     <= '0;
      hwdata    <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state     <= state_nxt;
      htrans    <= htrans_nxt;
      hwrite    <= hwrite_nxt;
      hsize     <= hsize_nxt;
      hprot     <= hprot_nxt;
      haddr     <= haddr_nxt;
      hwdata    <= hwdata_nxt;
      mem_ready <= ready_nxt;
      mem_err   <= err_nxt;
      mem_rdata <= rdata_nxt;
    end
  end

endmodule
